// File: rtl/vexriscv_loader_pkg.sv
// Shared types and constants for the VexRiscv RAM boot loader.
package vexriscv_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_FLUSH,
    S_RUN,
    S_ERR
  } state_e;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/vexriscv_ram_loader.sv
// Boot loader for the VexRiscv program/data RAM: loads a length-prefixed byte stream through
// the RAM data port while holding the CPU in reset, then hands the port to the CPU.
module vexriscv_ram_loader
  import vexriscv_loader_pkg::*;
#(
  parameter int unsigned RAM_DEPTH      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  localparam int unsigned AW            = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reload,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          err,
  output logic [AW:0]   words_loaded,
  input  logic          cpu_dbus_en,
  input  logic [3:0]    cpu_dbus_we,
  input  logic [AW-1:0] cpu_dbus_addr,
  input  logic [31:0]   cpu_dbus_din,
  output logic [31:0]   cpu_dbus_dout,
  output logic          ram_dbus_en,
  output logic [3:0]    ram_dbus_we,
  output logic [AW-1:0] ram_dbus_addr,
  output logic [31:0]   ram_dbus_din,
  input  logic [31:0]   ram_dbus_dout
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] DepthW = 32'(RAM_DEPTH);

  state_e        state_q, state_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   asm_q, asm_d;
  logic [31:0]   len_q, len_d;
  logic [AW:0]   words_q, words_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_din_q, wr_din_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;

  logic          accept;
  logic          counting;
  logic          tmo_hit;
  logic [31:0]   word;
  logic [AW:0]   words_inc;

  assign rx_ready      = (state_q == S_LEN) || (state_q == S_DATA);
  assign busy          = (state_q != S_RUN);
  assign err           = err_q;
  assign words_loaded  = words_q;
  assign cpu_rst_n     = cpu_rst_n_q;
  assign cpu_dbus_dout = ram_dbus_dout;

  assign accept    = rx_valid && rx_ready;
  assign word      = {rx_data, asm_q};
  assign words_inc = words_q + (AW + 1)'(1);
  // The header only times out once it has started arriving.
  assign counting  = (TIMEOUT_CYCLES != 0) &&
                     ((state_q == S_DATA) || ((state_q == S_LEN) && (byte_idx_q != 2'd0)));
  assign tmo_hit   = counting && !accept && (tmo_q == TmoLast);

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    len_d      = len_q;
    words_d    = words_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_din_d   = wr_din_q;

    if (reload) begin
      state_d    = S_LEN;
      byte_idx_d = '0;
      asm_d      = '0;
      len_d      = '0;
      words_d    = '0;
      err_d      = 1'b0;
      tmo_d      = '0;
      wr_addr_d  = '0;
      wr_din_d   = '0;
    end else if (tmo_hit) begin
      state_d    = S_LEN;
      byte_idx_d = '0;
      words_d    = '0;
      tmo_d      = '0;
    end else begin
      tmo_d = (accept || !counting) ? '0 : tmo_q + TW'(1);
      case (state_q)
        S_LEN: begin
          if (accept) begin
            asm_d      = word[31:8];
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'(HDR_BYTES - 1)) begin
              byte_idx_d = '0;
              len_d      = word;
              words_d    = '0;
              if (word == 32'd0) begin
                state_d = S_RUN;
              end else if (word > DepthW) begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end else begin
                state_d = S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            asm_d      = word[31:8];
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'(WORD_BYTES - 1)) begin
              byte_idx_d = '0;
              wr_en_d    = 1'b1;
              wr_addr_d  = words_q[AW-1:0];
              wr_din_d   = word;
              words_d    = words_inc;
              if (32'(words_inc) == len_q) begin
                state_d = S_FLUSH;
              end
            end
          end
        end
        S_FLUSH: state_d = S_RUN;
        default: ;
      endcase
    end

    cpu_rst_n_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN;
      byte_idx_q  <= '0;
      asm_q       <= '0;
      len_q       <= '0;
      words_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_din_q    <= '0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      asm_q       <= asm_d;
      len_q       <= len_d;
      words_q     <= words_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_din_q    <= wr_din_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // The CPU owns the RAM port only while running; otherwise only the loader strobe gets through.
  always_comb begin
    if (state_q == S_RUN) begin
      ram_dbus_en   = cpu_dbus_en;
      ram_dbus_we   = cpu_dbus_we;
      ram_dbus_addr = cpu_dbus_addr;
      ram_dbus_din  = cpu_dbus_din;
    end else begin
      ram_dbus_en   = wr_en_q;
      ram_dbus_we   = {4{wr_en_q}};
      ram_dbus_addr = wr_addr_q;
      ram_dbus_din  = wr_din_q;
    end
  end

endmodule

// File: tb/tb_vexriscv_ram_loader.sv
// Self-checking bench for vexriscv_ram_loader: table of load vectors plus hand-written corner cases.
module tb_vexriscv_ram_loader;

  localparam int unsigned RamDepth = 1024;
  localparam int unsigned Timeout  = 16;
  localparam int unsigned AW       = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          reload = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready;
  logic          cpu_rst_n;
  logic          busy;
  logic          err;
  logic [AW:0]   words_loaded;
  logic          cpu_dbus_en = 1'b0;
  logic [3:0]    cpu_dbus_we = '0;
  logic [AW-1:0] cpu_dbus_addr = '0;
  logic [31:0]   cpu_dbus_din = '0;
  logic [31:0]   cpu_dbus_dout;
  logic          ram_dbus_en;
  logic [3:0]    ram_dbus_we;
  logic [AW-1:0] ram_dbus_addr;
  logic [31:0]   ram_dbus_din;
  logic [31:0]   ram_dbus_dout = '0;

  vexriscv_ram_loader #(
    .RAM_DEPTH     (RamDepth),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reload       (reload),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .cpu_rst_n    (cpu_rst_n),
    .busy         (busy),
    .err          (err),
    .words_loaded (words_loaded),
    .cpu_dbus_en  (cpu_dbus_en),
    .cpu_dbus_we  (cpu_dbus_we),
    .cpu_dbus_addr(cpu_dbus_addr),
    .cpu_dbus_din (cpu_dbus_din),
    .cpu_dbus_dout(cpu_dbus_dout),
    .ram_dbus_en  (ram_dbus_en),
    .ram_dbus_we  (ram_dbus_we),
    .ram_dbus_addr(ram_dbus_addr),
    .ram_dbus_din (ram_dbus_din),
    .ram_dbus_dout(ram_dbus_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] len;
    int          nwords;
    logic [7:0]  base;
    logic        exp_err;
    logic        exp_run;
    logic [AW:0] exp_words;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  bit   ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
  endtask

  task automatic send_word32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i+:8]);
  endtask

  // Expected write is queued as the word's last byte is driven.
  task automatic send_data_word(input logic [AW-1:0] addr, input logic [31:0] w);
    for (int i = 0; i < 3; i++) send_byte(w[8*i+:8]);
    sb.push_back('{addr: addr, din: w});
    send_byte(w[31:24]);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic wait_run(input int max, output bit done);
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      if (cpu_rst_n === 1'b1) done = 1'b1;
      else tick();
    end
    if (cpu_rst_n === 1'b1) done = 1'b1;
  endtask

  function automatic logic [31:0] word_of(input logic [7:0] base, input int j);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k+:8] = 8'(int'(base) + 4 * j + k);
    return w;
  endfunction

  // Loader write monitor: any strobe while busy must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && ram_dbus_en && busy) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(ram_dbus_en), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ram_dbus_addr), 32'(e.addr));
        chk("wr_din", ram_dbus_din, e.din);
        chk("wr_we", 32'(ram_dbus_we), 32'hF);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"len3", 32'd3, 3, 8'h00, 1'b0, 1'b1, 11'd3};
    vecs[1] = '{"zero", 32'd0, 0, 8'h00, 1'b0, 1'b1, 11'd0};
    vecs[2] = '{"oversize", 32'd1025, 0, 8'h00, 1'b1, 1'b0, 11'd0};
    vecs[3] = '{"len2", 32'd2, 2, 8'h40, 1'b0, 1'b1, 11'd2};
    vecs[4] = '{"huge", 32'hFFFF_FFFF, 0, 8'h00, 1'b1, 1'b0, 11'd0};
    vecs[5] = '{"full", 32'd1024, 1024, 8'h10, 1'b0, 1'b1, 11'd1024};

    // Reset values
    #12;
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_words", 32'(words_loaded), 0);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_ram_en", 32'(ram_dbus_en), 0);
    chk("rst_ram_we", 32'(ram_dbus_we), 0);
    chk("rst_ram_addr", 32'(ram_dbus_addr), 0);
    chk("rst_ram_din", ram_dbus_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Normal load with exact strobe and release timing
    send_word32(32'd3);
    send_data_word(10'd0, 32'h0302_0100);
    chk("norm_strobe0_en", 32'(ram_dbus_en), 1);
    chk("norm_strobe0_words", 32'(words_loaded), 1);
    send_data_word(10'd1, 32'h0706_0504);
    send_data_word(10'd2, 32'h0B0A_0908);
    rx_valid = 1'b0;
    chk("norm_flush_en", 32'(ram_dbus_en), 1);
    chk("norm_flush_addr", 32'(ram_dbus_addr), 2);
    chk("norm_flush_din", ram_dbus_din, 32'h0B0A_0908);
    chk("norm_flush_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("norm_flush_rx_ready", 32'(rx_ready), 0);
    chk("norm_flush_words", 32'(words_loaded), 3);
    tick();
    chk("norm_release", 32'(cpu_rst_n), 1);
    chk("norm_busy", 32'(busy), 0);
    chk("norm_ram_en_idle", 32'(ram_dbus_en), 0);

    // CPU port mux in S_RUN
    cpu_dbus_en   = 1'b1;
    cpu_dbus_we   = 4'b0010;
    cpu_dbus_addr = 10'd5;
    cpu_dbus_din  = 32'hAABB_CCDD;
    ram_dbus_dout = 32'h5A5A_1234;
    #1;
    chk("mux_en", 32'(ram_dbus_en), 1);
    chk("mux_we", 32'(ram_dbus_we), 32'b0010);
    chk("mux_addr", 32'(ram_dbus_addr), 5);
    chk("mux_din", ram_dbus_din, 32'hAABB_CCDD);
    chk("mux_dout", cpu_dbus_dout, 32'h5A5A_1234);

    // CPU request in the reload cycle still reaches RAM, then is blocked
    reload = 1'b1;
    #1;
    chk("reload_cycle_cpu_en", 32'(ram_dbus_en), 1);
    tick();
    reload = 1'b0;
    #1;
    chk("load_cpu_blocked", 32'(ram_dbus_en), 0);
    chk("reload_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("reload_rx_ready", 32'(rx_ready), 1);
    chk("reload_words", 32'(words_loaded), 0);
    cpu_dbus_en = 1'b0;
    cpu_dbus_we = '0;

    // Table-driven loads
    foreach (vecs[v]) begin
      pulse_reload();
      chk({vecs[v].name, "_pre_err"}, 32'(err), 0);
      chk({vecs[v].name, "_pre_rx_ready"}, 32'(rx_ready), 1);
      chk({vecs[v].name, "_pre_cpu_rst_n"}, 32'(cpu_rst_n), 0);
      send_word32(vecs[v].len);
      for (int j = 0; j < vecs[v].nwords; j++) begin
        send_data_word(AW'(j), word_of(vecs[v].base, j));
      end
      rx_valid = 1'b0;
      if (vecs[v].exp_run) begin
        wait_run(8, ok);
      end else begin
        tick();
        tick();
      end
      chk({vecs[v].name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(vecs[v].exp_run));
      chk({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
      chk({vecs[v].name, "_busy"}, 32'(busy), 32'(!vecs[v].exp_run));
      chk({vecs[v].name, "_rx_ready"}, 32'(rx_ready), 0);
      chk({vecs[v].name, "_words"}, 32'(words_loaded), 32'(vecs[v].exp_words));
      chk({vecs[v].name, "_sb_empty"}, sb.size(), 0);
    end

    // Timeout mid-load
    pulse_reload();
    send_word32(32'd2);
    send_data_word(10'd0, 32'h4433_2211);
    send_byte(8'h55);
    rx_valid = 1'b0;
    repeat (15) tick();
    chk("tmo_before_words", 32'(words_loaded), 1);
    tick();
    chk("tmo_words", 32'(words_loaded), 0);
    chk("tmo_err", 32'(err), 0);
    chk("tmo_rx_ready", 32'(rx_ready), 1);
    chk("tmo_cpu_rst_n", 32'(cpu_rst_n), 0);
    send_word32(32'd1);
    send_data_word(10'd0, 32'h0D0C_0B0A);
    rx_valid = 1'b0;
    wait_run(8, ok);
    chk("tmo_reload_run", 32'(ok), 1);
    chk("tmo_reload_words", 32'(words_loaded), 1);

    // Reload in the same cycle as a byte drops the byte
    pulse_reload();
    send_word32(32'd2);
    send_byte(8'hA0);
    send_byte(8'hA1);
    reload   = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    tick();
    reload   = 1'b0;
    rx_valid = 1'b0;
    chk("rlb_rx_ready", 32'(rx_ready), 1);
    chk("rlb_words", 32'(words_loaded), 0);
    chk("rlb_ram_en", 32'(ram_dbus_en), 0);
    send_word32(32'd1);
    send_data_word(10'd0, 32'hCAFE_F00D);
    rx_valid = 1'b0;
    wait_run(8, ok);
    chk("rlb_run", 32'(ok), 1);
    chk("rlb_words_done", 32'(words_loaded), 1);

    // Asynchronous reset mid-word
    pulse_reload();
    send_word32(32'd2);
    send_data_word(10'd0, 32'h1122_3344);
    send_byte(8'h01);
    send_byte(8'h02);
    rx_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("arst_busy", 32'(busy), 1);
    chk("arst_err", 32'(err), 0);
    chk("arst_words", 32'(words_loaded), 0);
    chk("arst_rx_ready", 32'(rx_ready), 1);
    chk("arst_ram_en", 32'(ram_dbus_en), 0);
    chk("arst_ram_addr", 32'(ram_dbus_addr), 0);
    chk("arst_ram_din", ram_dbus_din, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vexriscv_ram_loader.md
# vexriscv_ram_loader

Boot loader and data-port arbiter for the VexRiscv dual-port program/data RAM. Holds the CPU in reset, receives a length-prefixed little-endian byte stream, assembles 32-bit words, and writes them through the RAM data-bus port. After the load it releases the CPU and passes the CPU data bus straight through to the same RAM port.

## Interface
- `RAM_DEPTH`, 1024: RAM depth in 32-bit words. `AW = $clog2(RAM_DEPTH)`.
- `TIMEOUT_CYCLES`, 1_000_000: inter-byte timeout while loading. 0 disables the timeout.
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, asynchronous and active-low.
- `reload` in 1: one-cycle pulse that restarts the load.
- `rx_valid` in 1, `rx_data` in 8, `rx_ready` out 1: byte stream. A byte transfers when valid and ready are both high.
- `cpu_rst_n` out 1: CPU reset. Low while loading.
- `busy` out 1: high in every state except S_RUN.
- `err` out 1: length error flag. Sticky until reload or reset.
- `words_loaded` out AW+1: count of words written so far.
- `cpu_dbus_en`, `cpu_dbus_we[3:0]`, `cpu_dbus_addr[AW-1:0]`, `cpu_dbus_din[31:0]` in: CPU data-bus request.
- `cpu_dbus_dout` out 32: wired directly to `ram_dbus_dout`.
- `ram_dbus_en`, `ram_dbus_we[3:0]`, `ram_dbus_addr[AW-1:0]`, `ram_dbus_din[31:0]` out: RAM data-bus port.
- `ram_dbus_dout` in 32: RAM read data.

## Operation
- States: S_LEN, S_DATA, S_FLUSH, S_RUN, S_ERR.
- **S_LEN**
  - Collects 4 bytes, LSB first, into a 32-bit length N.
  - On the 4th byte, if N == 0, go to S_RUN.
  - If N > RAM_DEPTH, go to S_ERR and set `err` = 1.
  - Otherwise go to S_DATA. Word index and `words_loaded` are 0.
- **S_DATA**
  - Collects bytes, LSB first. Byte k of a word lands in bits [8k+7:8k].
  - On the 4th byte, register a write: en = 1, we = 4'hF, addr = word index, din = assembled word.
  - Then increment the word index. When the index reaches N, go to S_FLUSH.
- **S_FLUSH**: one cycle in which the final write is presented to RAM, then go to S_RUN.
- **S_RUN**: RAM port mirrors the CPU port combinationally (en, we, addr, din).
- **S_ERR**: no RAM access. CPU held in reset. Exit only via `reload`.
- **Port mux**
  - In every state except S_RUN, the RAM port carries only the loader write strobe; CPU requests are ignored.
  - `cpu_dbus_dout` always equals `ram_dbus_dout`.
- **`rx_ready`**: 1 in S_LEN and S_DATA; 0 in S_FLUSH, S_RUN and S_ERR.
- **`reload`**
  - From any state, go to S_LEN on the next edge. Clear `err`, byte count, word index and `words_loaded`; drive `cpu_rst_n` = 0.
  - `reload` has priority: a byte transferred in the same cycle is discarded.
- **Timeout**
  - The counter clears on every accepted byte.
  - It counts in S_DATA, and in S_LEN when the byte index is nonzero.
  - When it reaches TIMEOUT_CYCLES, go to S_LEN with all counters cleared. `err` is not set.
- **Arithmetic**
  - Compare the length as an unsigned 32-bit value against RAM_DEPTH.
  - `words_loaded` is AW+1 bits so that it can hold RAM_DEPTH.

## Timing
- **Reset values**
  - State S_LEN, `cpu_rst_n` = 0, `busy` = 1, `err` = 0, `words_loaded` = 0.
  - `rx_ready` = 1, `ram_dbus_en` = 0, `ram_dbus_we` = 0.
  - `ram_dbus_addr` = 0, `ram_dbus_din` = 0.
- **Write latency**: the RAM write strobe is high exactly one cycle, the cycle after the 4th byte of a word is accepted.
- **Back-to-back bytes**: accepted at 1 byte/cycle with no stall. The strobe for word i overlaps collection of word i+1.
- **`words_loaded`**: increments in the same cycle the strobe is high.
- **Release**: `cpu_rst_n` is registered and reads 1 from the first S_RUN cycle. The last write (S_FLUSH) always precedes it.
- **Simultaneous events**
  - A mid-load reset (`rst_n`) acts like `reload`, but asynchronously.
  - A CPU request in the cycle `reload` is sampled in S_RUN still reaches RAM.

## Structure
- Package `vexriscv_loader_pkg` holds:
  - the state enum;
  - `HDR_BYTES` = 4;
  - `WORD_BYTES` = 4.
- No sub-module is required. Byte assembly, the timeout counter and the mux all live in one module.

## Test plan
- **Normal load**: length 3 then 12 bytes 00..0B.
  - RAM writes at addr 0/1/2 of 0x03020100 / 0x07060504 / 0x0B0A0908.
  - `cpu_rst_n` rises one cycle after the 3rd strobe.
  - `words_loaded` = 3.
- **Zero length**: length 0. Go to S_RUN, `cpu_rst_n` = 1, no RAM writes.
- **Oversize length**: RAM_DEPTH + 1 (RAM_DEPTH = 1024).
  - `err` = 1, `rx_ready` = 0, `cpu_rst_n` = 0, no writes.
  - `reload` clears `err` and `rx_ready` returns to 1.
- **Timeout**: TIMEOUT_CYCLES = 16, length 2, then 5 bytes, then idle 16 cycles.
  - Returns to S_LEN, `words_loaded` = 0.
  - A fresh length 1 + 4 bytes loads correctly at addr 0.
- **Mux in S_RUN**: CPU write addr 5, we 4'b0010, din 0xAABBCCDD.
  - Appears on the RAM port in the same cycle.
  - During loading, a CPU request leaves `ram_dbus_en` = 0.
- **Reload/mid-load reset**: `reload` on the same cycle as a byte, and `rst_n` low mid-word.
  - The byte is dropped and the state is S_LEN.
  - All outputs show their reset values.
